// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
//
// Purpose:
//   Arbitrates between the fetch path and the load/store path, issues a single
//   memory command for the winner, waits out the memory read latency, then
//   returns the read data together with a one-cycle acknowledge to the winner.
//   Sequence per access: IDLE -> ISSUE (1 cycle) -> WAIT (READ_LATENCY cycles)
//   -> ACK (1 cycle) -> IDLE.
//
// Ports:
//   i_Clock, i_Reset_N          clock (rising edge), asynchronous active-low reset
//   i_Fetch_Req/_Addr           fetch request (held until ack) and byte address
//   o_Fetch_Ack/_Data           one-cycle fetch completion pulse and fetched word
//   i_Data_Req/_Write_Enable    load/store request (held until ack), 1 = store
//   i_Data_Load_Store_Type      byte/half/word and signedness code
//   i_Data_Addr/_Write_Data     load/store byte address and store data
//   o_Data_Ack/_Read_Data       one-cycle load/store completion pulse and load result
//   o_Mem_*                     memory command: enable, write enable, type, address, data
//   i_Mem_Read_Data             memory read data, valid READ_LATENCY cycles after the command
//   o_Busy                      high in every state except IDLE
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN      defined: simultaneous requests alternate between the
//                               ports; undefined: load/store always beats fetch.

module mem_port_arbiter #(
   parameter int XLEN         = 32,
   parameter int READ_LATENCY = 1,
   parameter int LS_SEL_WIDTH = 2,
   parameter int LS_WIDTH     = LS_SEL_WIDTH + 1
) (
   input  logic                i_Clock,
   input  logic                i_Reset_N,
   input  logic                i_Fetch_Req,
   input  logic [XLEN-1:0]     i_Fetch_Addr,
   output logic                o_Fetch_Ack,
   output logic [XLEN-1:0]     o_Fetch_Data,
   input  logic                i_Data_Req,
   input  logic                i_Data_Write_Enable,
   input  logic [LS_WIDTH-1:0] i_Data_Load_Store_Type,
   input  logic [XLEN-1:0]     i_Data_Addr,
   input  logic [XLEN-1:0]     i_Data_Write_Data,
   output logic                o_Data_Ack,
   output logic [XLEN-1:0]     o_Data_Read_Data,
   output logic                o_Mem_Enable,
   output logic                o_Mem_Write_Enable,
   output logic [LS_WIDTH-1:0] o_Mem_Load_Store_Type,
   output logic [XLEN-1:0]     o_Mem_Addr,
   output logic [XLEN-1:0]     o_Mem_Write_Data,
   input  logic [XLEN-1:0]     i_Mem_Read_Data,
   output logic                o_Busy
);

   // Fetches always read a full word.
   localparam logic [LS_WIDTH-1:0] LS_TYPE_WORD = LS_WIDTH'(2);
   // Holds READ_LATENCY-1, and READ_LATENCY tops out at 7.
   localparam int CNT_WIDTH = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_ACK   = 2'd3
   } state_t;

   typedef enum logic {
      GRANT_FETCH = 1'b0,
      GRANT_DATA  = 1'b1
   } grant_t;

   state_t               r_State;
   state_t               w_Next_State;
   grant_t               r_Last_Grant;
   grant_t               w_Grant;
   logic                 w_Take;
   logic                 w_Capture;
   logic [CNT_WIDTH-1:0] r_Wait_Count;
   logic [XLEN-1:0]      r_Addr;
   logic [XLEN-1:0]      r_Write_Data;
   logic                 r_Write_Enable;
   logic [LS_WIDTH-1:0]  r_Type;
   logic [XLEN-1:0]      r_Fetch_Data;
   logic [XLEN-1:0]      r_Data_Read_Data;

   // State register
   always_ff @(posedge i_Clock or negedge i_Reset_N) begin
      if (!i_Reset_N) begin
         r_State <= S_IDLE;
      end else begin
         r_State <= w_Next_State;
      end
   end

   // Next state, grant selection and strobes
   always_comb begin
      w_Next_State       = r_State;
      w_Take             = 1'b0;
      w_Capture          = 1'b0;
      o_Mem_Enable       = 1'b0;
      o_Mem_Write_Enable = 1'b0;
      o_Fetch_Ack        = 1'b0;
      o_Data_Ack         = 1'b0;
      o_Busy             = (r_State != S_IDLE);

`ifdef MEM_ARB_ROUND_ROBIN_EN
      // On a tie, the port that did not win last time goes next.
      if (i_Data_Req && (!i_Fetch_Req || (r_Last_Grant == GRANT_FETCH))) begin
         w_Grant = GRANT_DATA;
      end else begin
         w_Grant = GRANT_FETCH;
      end
`else
      w_Grant = i_Data_Req ? GRANT_DATA : GRANT_FETCH;
`endif

      case (r_State)
         S_IDLE: begin
            if (i_Fetch_Req || i_Data_Req) begin
               w_Take       = 1'b1;
               w_Next_State = S_ISSUE;
            end
         end
         S_ISSUE: begin
            o_Mem_Enable       = 1'b1;
            o_Mem_Write_Enable = r_Write_Enable;
            w_Next_State       = S_WAIT;
         end
         S_WAIT: begin
            if (r_Wait_Count == '0) begin
               w_Capture    = 1'b1;
               w_Next_State = S_ACK;
            end
         end
         S_ACK: begin
            o_Fetch_Ack  = (r_Last_Grant == GRANT_FETCH);
            o_Data_Ack   = (r_Last_Grant == GRANT_DATA);
            w_Next_State = S_IDLE;
         end
         default: begin
            w_Next_State = S_IDLE;
         end
      endcase
   end

   // Command latch, wait counter and per-port read data
   always_ff @(posedge i_Clock or negedge i_Reset_N) begin
      if (!i_Reset_N) begin
         r_Last_Grant     <= GRANT_DATA;
         r_Wait_Count     <= '0;
         r_Addr           <= '0;
         r_Write_Data     <= '0;
         r_Write_Enable   <= 1'b0;
         r_Type           <= '0;
         r_Fetch_Data     <= '0;
         r_Data_Read_Data <= '0;
      end else begin
         // The payload is captured only at grant, so later changes on the
         // request inputs cannot disturb an access in progress.
         if (w_Take) begin
            r_Last_Grant <= w_Grant;
            if (w_Grant == GRANT_DATA) begin
               r_Addr         <= i_Data_Addr;
               r_Write_Data   <= i_Data_Write_Data;
               r_Write_Enable <= i_Data_Write_Enable;
               r_Type         <= i_Data_Load_Store_Type;
            end else begin
               r_Addr         <= i_Fetch_Addr;
               r_Write_Data   <= '0;
               r_Write_Enable <= 1'b0;
               r_Type         <= LS_TYPE_WORD;
            end
         end

         if (r_State == S_ISSUE) begin
            r_Wait_Count <= CNT_WIDTH'(READ_LATENCY - 1);
         end else if ((r_State == S_WAIT) && (r_Wait_Count != '0)) begin
            r_Wait_Count <= r_Wait_Count - 1'b1;
         end

         // Only the winner's result register moves; the other keeps its last value.
         if (w_Capture) begin
            if (r_Last_Grant == GRANT_FETCH) begin
               r_Fetch_Data <= i_Mem_Read_Data;
            end else begin
               r_Data_Read_Data <= i_Mem_Read_Data;
            end
         end
      end
   end

   assign o_Mem_Addr            = r_Addr;
   assign o_Mem_Write_Data      = r_Write_Data;
   assign o_Mem_Load_Store_Type = r_Type;
   assign o_Fetch_Data          = r_Fetch_Data;
   assign o_Data_Read_Data      = r_Data_Read_Data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (latency 1 and 3 instances)

`timescale 1ns/1ps

module tb_mem_port_arbiter;

   localparam logic [2:0] LS_W = 3'b010;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit TIE_DATA_FIRST = 1'b0;
`else
   localparam bit TIE_DATA_FIRST = 1'b1;
`endif

   typedef struct {
      int          d;
      bit          fr;
      bit          dr;
      bit          we;
      logic [2:0]  lst;
      logic [31:0] faddr;
      logic [31:0] daddr;
      logic [31:0] wdata;
      bit          first_data;
   } vec_t;

   typedef struct {
      int          d;
      bit          is_fetch;
      logic [31:0] addr;
      bit          we;
      logic [2:0]  lst;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n      [2];
   logic        fetch_req  [2];
   logic [31:0] fetch_addr [2];
   logic        fack       [2];
   logic [31:0] fdata      [2];
   logic        data_req   [2];
   logic        data_we    [2];
   logic [2:0]  data_lst   [2];
   logic [31:0] data_addr  [2];
   logic [31:0] data_wdata [2];
   logic        dack       [2];
   logic [31:0] drdata     [2];
   logic        mem_en     [2];
   logic        mem_we     [2];
   logic [2:0]  mem_lst    [2];
   logic [31:0] mem_addr   [2];
   logic [31:0] mem_wdata  [2];
   logic [31:0] mem_rdata  [2];
   logic        busy       [2];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   vec_t        vt [11];
   exp_t        cmdq [$];
   exp_t        ackq [$];
   logic [31:0] last_fetch [2];
   logic [31:0] last_data  [2];
   bit          ldv        [2];
   int          pend       [2];
   logic [31:0] maddr      [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   genvar g;
   generate
      for (g = 0; g < 2; g++) begin : g_dut
         mem_port_arbiter #(.READ_LATENCY((g == 0) ? 1 : 3)) u_dut (
            .i_Clock                (clk),
            .i_Reset_N              (rst_n[g]),
            .i_Fetch_Req            (fetch_req[g]),
            .i_Fetch_Addr           (fetch_addr[g]),
            .o_Fetch_Ack            (fack[g]),
            .o_Fetch_Data           (fdata[g]),
            .i_Data_Req             (data_req[g]),
            .i_Data_Write_Enable    (data_we[g]),
            .i_Data_Load_Store_Type (data_lst[g]),
            .i_Data_Addr            (data_addr[g]),
            .i_Data_Write_Data      (data_wdata[g]),
            .o_Data_Ack             (dack[g]),
            .o_Data_Read_Data       (drdata[g]),
            .o_Mem_Enable           (mem_en[g]),
            .o_Mem_Write_Enable     (mem_we[g]),
            .o_Mem_Load_Store_Type  (mem_lst[g]),
            .o_Mem_Addr             (mem_addr[g]),
            .o_Mem_Write_Data       (mem_wdata[g]),
            .i_Mem_Read_Data        (mem_rdata[g]),
            .o_Busy                 (busy[g])
         );
      end
   endgenerate

   function automatic int rl(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic logic [31:0] memval(input logic [31:0] a);
      if (a == 32'h40) return 32'h00500093;
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", nm, d, cyc, act, req);
      end
   endtask

   // Memory: read data is correct only in the single cycle READ_LATENCY after the command.
   always @(negedge clk) begin : mem_model
      logic hit;
      for (int d = 0; d < 2; d++) begin
         hit = 1'b0;
         if (!rst_n[d]) begin
            pend[d] = 0;
         end else if (mem_en[d]) begin
            pend[d]  = rl(d);
            maddr[d] = mem_addr[d];
         end else if (pend[d] > 0) begin
            pend[d] = pend[d] - 1;
            hit     = (pend[d] == 0);
         end
         mem_rdata[d] = hit ? memval(maddr[d]) : {16'hBAD0, 16'(cyc)};
      end
   end

   // Scoreboard monitor: commands and acks are compared against queued expectations.
   always @(negedge clk) begin : monitor
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (rst_n[d]) begin
            if (mem_en[d]) begin
               if (cmdq.size() == 0 || cmdq[0].d != d) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_cmd dut%0d cyc=%0d actual addr=%h required no command", d, cyc, mem_addr[d]);
               end else begin
                  e = cmdq.pop_front();
                  chk("cmd_cycle", d, 32'(cyc), 32'(e.cyc));
                  chk("cmd_addr", d, mem_addr[d], e.addr);
                  chk("cmd_we", d, 32'(mem_we[d]), 32'(e.we));
                  chk("cmd_type", d, 32'(mem_lst[d]), 32'(e.lst));
                  if (!e.is_fetch) chk("cmd_wdata", d, mem_wdata[d], e.wdata);
               end
            end
            if (fack[d] || dack[d]) begin
               if (ackq.size() == 0 || ackq[0].d != d) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_ack dut%0d cyc=%0d actual fack=%0b dack=%0b required none", d, cyc, fack[d], dack[d]);
               end else begin
                  e = ackq.pop_front();
                  chk("ack_cycle", d, 32'(cyc), 32'(e.cyc));
                  chk("ack_fetch", d, 32'(fack[d]), 32'(e.is_fetch));
                  chk("ack_data", d, 32'(dack[d]), 32'(!e.is_fetch));
                  if (e.is_fetch) begin
                     chk("fetch_data", d, fdata[d], e.rdata);
                     if (ldv[d]) chk("data_hold", d, drdata[d], last_data[d]);
                     last_fetch[d] = e.rdata;
                  end else begin
                     if (!e.we) chk("load_data", d, drdata[d], e.rdata);
                     chk("fetch_hold", d, fdata[d], last_fetch[d]);
                     ldv[d]       = !e.we;
                     last_data[d] = e.rdata;
                  end
               end
            end
         end
      end
   end

   task automatic check_zero(input int d);
      chk("rst_mem_en", d, 32'(mem_en[d]), 32'd0);
      chk("rst_mem_we", d, 32'(mem_we[d]), 32'd0);
      chk("rst_mem_type", d, 32'(mem_lst[d]), 32'd0);
      chk("rst_mem_addr", d, mem_addr[d], 32'd0);
      chk("rst_mem_wdata", d, mem_wdata[d], 32'd0);
      chk("rst_fetch_ack", d, 32'(fack[d]), 32'd0);
      chk("rst_data_ack", d, 32'(dack[d]), 32'd0);
      chk("rst_fetch_data", d, fdata[d], 32'd0);
      chk("rst_data_rdata", d, drdata[d], 32'd0);
      chk("rst_busy", d, 32'(busy[d]), 32'd0);
   endtask

   task automatic run_vec(input int i);
      vec_t        v;
      exp_t        e;
      int          d, r, t, n, base;
      bit          order [2];
      logic [31:0] kaddr [2];
      bit          kwe   [2];
      bit          done, busy_exp, we_exp;
      v = vt[i];
      d = v.d;
      r = rl(d);
      @(negedge clk);
      t = cyc;
      fetch_addr[d] = v.faddr;
      data_addr[d]  = v.daddr;
      data_we[d]    = v.we;
      data_lst[d]   = v.lst;
      data_wdata[d] = v.wdata;
      fetch_req[d]  = v.fr;
      data_req[d]   = v.dr;
      n = int'(v.fr) + int'(v.dr);
      order[0] = (v.fr && v.dr) ? v.first_data : v.dr;
      order[1] = !order[0];
      for (int k = 0; k < n; k++) begin
         base       = t + k * (r + 3);
         e.d        = d;
         e.is_fetch = !order[k];
         e.addr     = order[k] ? v.daddr : v.faddr;
         e.we       = order[k] ? v.we : 1'b0;
         e.lst      = order[k] ? v.lst : LS_W;
         e.wdata    = order[k] ? v.wdata : 32'd0;
         e.rdata    = memval(e.addr);
         kaddr[k]   = e.addr;
         kwe[k]     = e.we;
         e.cyc      = base + 1;
         cmdq.push_back(e);
         e.cyc      = base + 2 + r;
         ackq.push_back(e);
      end
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         busy_exp = 1'b0;
         we_exp   = 1'b0;
         for (int k = 0; k < n; k++) begin
            base = t + k * (r + 3);
            if (cyc >= base + 1 && cyc <= base + 2 + r) busy_exp = 1'b1;
            if (cyc == base + 1) we_exp = kwe[k];
            if (cyc >= base + 2 && cyc <= base + 1 + r) chk("wait_addr_hold", d, mem_addr[d], kaddr[k]);
         end
         chk("busy", d, 32'(busy[d]), 32'(busy_exp));
         chk("mem_we", d, 32'(mem_we[d]), 32'(we_exp));
         // Disturb the winner's payload once it has been granted.
         if (cyc == t + 1) begin
            if (order[0]) begin
               data_addr[d]  = ~v.daddr;
               data_wdata[d] = ~v.wdata;
               data_we[d]    = ~v.we;
            end else begin
               fetch_addr[d] = ~v.faddr;
            end
         end
         if (fack[d]) fetch_req[d] = 1'b0;
         if (dack[d]) data_req[d] = 1'b0;
         if (!fetch_req[d] && !data_req[d]) done = 1'b1;
         else @(negedge clk);
      end
      chk("complete", d, 32'(done), 32'd1);
      if (!done) begin
         fetch_req[d] = 1'b0;
         data_req[d]  = 1'b0;
         cmdq.delete();
         ackq.delete();
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1);
   end

   initial begin : main
      exp_t e;
      int   t;
      //         d  fr dr we lst     faddr       daddr      wdata          first_data
      vt[0]  = '{0, 1, 0, 0, LS_W,   32'h40,     32'h0,     32'h0,         1'b0};
      vt[1]  = '{0, 0, 1, 1, LS_W,   32'h0,      32'h100,   32'hDEADBEEF,  1'b1};
      vt[2]  = '{0, 0, 1, 0, 3'b100, 32'h0,      32'h24,    32'h0,         1'b1};
      vt[3]  = '{0, 1, 1, 0, LS_W,   32'h44,     32'h200,   32'h0,         TIE_DATA_FIRST};
      vt[4]  = '{0, 1, 1, 1, 3'b001, 32'h48,     32'h204,   32'hCAFEF00D,  TIE_DATA_FIRST};
      vt[5]  = '{0, 1, 1, 0, 3'b101, 32'h4C,     32'h206,   32'h0,         TIE_DATA_FIRST};
      vt[6]  = '{0, 1, 1, 1, LS_W,   32'h50,     32'h208,   32'h0BADCAFE,  TIE_DATA_FIRST};
      vt[7]  = '{1, 0, 1, 0, LS_W,   32'h0,      32'h8,     32'h0,         1'b1};
      vt[8]  = '{1, 1, 0, 0, LS_W,   32'h1000,   32'h0,     32'h0,         1'b0};
      vt[9]  = '{1, 1, 1, 1, 3'b000, 32'h2000,   32'h300,   32'h12345678,  1'b1};
      vt[10] = '{1, 0, 1, 0, 3'b001, 32'h0,      32'h44,    32'h0,         1'b1};

      for (int d = 0; d < 2; d++) begin
         rst_n[d]      = 1'b0;
         fetch_req[d]  = 1'b0;
         fetch_addr[d] = 32'h0;
         data_req[d]   = 1'b0;
         data_we[d]    = 1'b0;
         data_lst[d]   = 3'b0;
         data_addr[d]  = 32'h0;
         data_wdata[d] = 32'h0;
         mem_rdata[d]  = 32'h0;
         last_fetch[d] = 32'h0;
         last_data[d]  = 32'h0;
         ldv[d]        = 1'b1;
         pend[d]       = 0;
         maddr[d]      = 32'h0;
      end
      repeat (2) @(negedge clk);
      check_zero(0);
      check_zero(1);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(i);

      // Reset in the middle of a latency-3 load: outputs clear at once, no ack follows.
      @(negedge clk);
      t             = cyc;
      data_addr[1]  = 32'h8;
      data_we[1]    = 1'b0;
      data_lst[1]   = LS_W;
      data_wdata[1] = 32'h0;
      data_req[1]   = 1'b1;
      e = '{1, 1'b0, 32'h8, 1'b0, LS_W, 32'h0, 32'h0, t + 1};
      cmdq.push_back(e);
      for (int c = 0; c < 10 && cyc < t + 3; c++) @(negedge clk);
      chk("rst_wait_reached", 1, 32'(cyc), 32'(t + 3));
      chk("rst_busy_before", 1, 32'(busy[1]), 32'd1);
      rst_n[1] = 1'b0;
      #1;
      check_zero(1);
      data_req[1]   = 1'b0;
      last_fetch[1] = 32'h0;
      last_data[1]  = 32'h0;
      ldv[1]        = 1'b1;
      repeat (3) @(negedge clk);
      check_zero(1);
      rst_n[1] = 1'b1;

      run_vec(10);
      repeat (2) @(negedge clk);
      chk("cmdq_drained", 0, 32'(cmdq.size()), 32'd0);
      chk("ackq_drained", 0, 32'(ackq.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
